usb_uart_deframer: RTL
======================

# usb_uart_deframer

Byte-stream deframer directly downstream of the USB UART's out pipe (host to device). The USB link carries no start/stop markers, so the host sends SLIP-style escaped frames. This block strips the escaping and re-creates frame boundaries. It emits data bytes with start/stop flags to the application on a valid/ready handshake and keeps a saturating protocol-error count.

## Interface
Parameters:
- END_CHAR, 8'hC0, frame delimiter
- ESC_CHAR, 8'hDB, escape prefix
- ESC_END, 8'hDC, escaped code for END_CHAR
- ESC_ESC, 8'hDD, escaped code for ESC_CHAR

Ports:
- clk_48mhz  input  1  single clock, all logic rising-edge
- reset  input  1  synchronous, active-high
- in_data  input  8  byte from USB UART out pipe
- in_valid  input  1  in_data valid
- in_ready  output  1  byte accepted when in_valid && in_ready
- out_data  output  8  unescaped payload byte
- out_start  output  1  first byte of a frame
- out_stop  output  1  last byte of a frame
- out_valid  output  1  out_* valid
- out_ready  input  1  downstream accepts when out_valid && out_ready
- err_count  output  8  saturating protocol-error count

## Operation
- Two byte registers:
  - hold: hold_valid, hold_data, hold_start
  - output: out_valid, out_data, out_start, out_stop
- Bytes are held one deep so the last byte can carry stop when END arrives.
- in_ready = !out_valid || out_ready. It is combinational from out_ready and does not depend on state.
- The term "push" below means: hold moves to the output register and hold_valid clears. This is legal only on an accepted input cycle, because in_ready guarantees the output register is free that cycle.

States: IDLE (between frames, next data byte sets start), FRAME, ESC, DISCARD.
- IDLE:
  - END_CHAR: ignored, so empty frames are dropped.
  - ESC_CHAR: go to ESC, with start pending.
  - Other byte: hold = {byte, start=1}, go to FRAME.
- FRAME:
  - Data byte: push hold with stop=0, hold = {byte, start=0}.
  - ESC_CHAR: go to ESC.
  - END_CHAR: push hold with stop=1, go to IDLE.
- ESC:
  - ESC_END or ESC_ESC: decoded byte (END_CHAR or ESC_CHAR) is treated as a data byte. Start is 1 if the escape began in IDLE. Go to FRAME.
  - END_CHAR: error. Push hold (if valid) with stop=1, increment err_count, go to IDLE.
  - Any other byte: error. Push hold (if valid) with stop=1, increment err_count, go to DISCARD.
- DISCARD:
  - All bytes dropped until END_CHAR, then go to IDLE. A frame truncated by an error is therefore delivered properly terminated.
- A single-byte frame is output with start=1 and stop=1.
- err_count saturates at 8'hFF.
- Reset mid-frame:
  - Clears hold, output, state (to IDLE) and err_count.
  - Any partially delivered frame is left without stop. The downstream must treat a reset as a frame abort.

## Timing
- Reset values:
  - in_ready = 1 (because out_valid = 0)
  - out_valid = 0, out_data = 0, out_start = 0, out_stop = 0
  - err_count = 0
  - State IDLE, hold_valid = 0
- Input is registered. A pushed byte appears on out_* the cycle after the accepting input edge.
- Latency of a payload byte is not fixed: it leaves hold only when the following data byte or END_CHAR is accepted.
- out_* is stable while out_valid && !out_ready. out_valid clears the cycle after acceptance unless a new push occurs on the same edge.
- Simultaneous output accept and input accept on the same edge are legal. This gives a sustained rate of 1 byte/cycle, with no bubble.
- in_valid with in_ready = 0: input is ignored and the byte must be held by the source.

## Configuration
- USB_DEFRAMER_ERRCNT_EN:
  - Defined: err_count counter is implemented as above.
  - Undefined: counter is removed and err_count is tied to 8'h00.
- State machine error handling is identical in both cases (truncate, DISCARD).

## Test plan
- Input C0 11 22 33 C0, out_ready=1 -> output 11(start), 22, 33(stop); err_count=0.
- Input C0 DB DC DB DD 44 C0 -> output C0(start), DB, 44(stop).
- Input C0 C0 55 C0 -> single output 55 with start=1, stop=1; empty frame dropped.
- Input C0 66 77 DB 12 88 99 C0 AA C0 -> 66(start), 77(stop); 88 and 99 discarded; AA(start, stop); err_count=1.
- out_ready toggled by a random 50% pattern on a 200-byte escaped frame -> out_* stable during stalls, no loss or duplication, stop only on byte 200.
- 300 frames each containing DB 00 -> err_count saturates at FF. Pulse reset mid-frame -> all outputs return to reset values, and the next frame's first byte has start=1.

Source files
------------

// File: rtl/usb_uart_deframer.sv
// SLIP-style deframer: strips escaping from the USB UART byte stream and emits framed bytes.
// Optional error counter enabled by defining USB_DEFRAMER_ERRCNT_EN (err_count tied to 0 otherwise).
module usb_uart_deframer #(
    parameter logic [7:0] END_CHAR = 8'hC0,
    parameter logic [7:0] ESC_CHAR = 8'hDB,
    parameter logic [7:0] ESC_END  = 8'hDC,
    parameter logic [7:0] ESC_ESC  = 8'hDD
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_start,
    output logic       out_stop,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] err_count
);

    // Handshake: a byte moves on any edge where valid && ready are both high;
    // the source holds data stable while valid is high and ready is low.
    typedef enum logic [1:0] {IDLE, FRAME, ESC, DISCARD} state_t;

    state_t     state, state_n;
    logic       esc_start, esc_start_n;
    logic       hold_valid, hold_start;
    logic [7:0] hold_data;
    logic       accept;
    logic       load, load_start, push, push_stop;
    logic [7:0] load_data;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state     <= IDLE;
            esc_start <= 1'b0;
        end else begin
            state     <= state_n;
            esc_start <= esc_start_n;
        end
    end

    always_comb begin
        state_n     = state;
        esc_start_n = esc_start;
        load        = 1'b0;
        load_data   = in_data;
        load_start  = 1'b0;
        push        = 1'b0;
        push_stop   = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (in_data == ESC_CHAR) begin
                        state_n     = ESC;
                        esc_start_n = 1'b1;
                    end else if (in_data != END_CHAR) begin
                        load       = 1'b1;
                        load_start = 1'b1;
                        state_n    = FRAME;
                    end
                end
                FRAME: begin
                    if (in_data == ESC_CHAR) begin
                        state_n     = ESC;
                        esc_start_n = 1'b0;
                    end else if (in_data == END_CHAR) begin
                        push      = hold_valid;
                        push_stop = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        push = hold_valid;
                        load = 1'b1;
                    end
                end
                ESC: begin
                    if (in_data == ESC_END || in_data == ESC_ESC) begin
                        // hold is empty when the escape opened the frame, so push is a no-op then
                        push       = hold_valid;
                        load       = 1'b1;
                        load_data  = (in_data == ESC_END) ? END_CHAR : ESC_CHAR;
                        load_start = esc_start;
                        state_n    = FRAME;
                    end else begin
                        push      = hold_valid;
                        push_stop = 1'b1;
                        state_n   = (in_data == END_CHAR) ? IDLE : DISCARD;
                    end
                end
                DISCARD: begin
                    if (in_data == END_CHAR) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_data  <= 8'h00;
            hold_start <= 1'b0;
        end else if (load) begin
            hold_valid <= 1'b1;
            hold_data  <= load_data;
            hold_start <= load_start;
        end else if (push) begin
            hold_valid <= 1'b0;
        end
    end

    // push only happens on an accepted cycle, so the output register is free
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_start <= 1'b0;
            out_stop  <= 1'b0;
        end else if (push) begin
            out_valid <= 1'b1;
            out_data  <= hold_data;
            out_start <= hold_start;
            out_stop  <= push_stop;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef USB_DEFRAMER_ERRCNT_EN
    logic       err_inc;
    logic [7:0] err_q;

    assign err_inc = accept && (state == ESC) && (in_data != ESC_END) && (in_data != ESC_ESC);

    always_ff @(posedge clk_48mhz) begin
        if (reset)
            err_q <= 8'h00;
        else if (err_inc && err_q != 8'hFF)
            err_q <= err_q + 8'h01;
    end

    assign err_count = err_q;
`else
    assign err_count = 8'h00;
`endif

endmodule
